// File: rtl/reg_file8_pkg.sv
// Shared constants and FSM encoding for the 8-entry register file.
package reg_file8_pkg;
  localparam int REG_COUNT = 8;
  localparam int ADDR_W    = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;
endpackage

// File: rtl/reg_file8_dmux8.sv
// 1-to-8 demultiplexer: routes i_in to the selected output, all others 0.
module dmux8
  import reg_file8_pkg::*;
#(
  parameter int BUS_WIDTH = 1
) (
  input  logic [BUS_WIDTH-1:0]                i_in,
  input  logic [ADDR_W-1:0]                   i_sel,
  output logic [REG_COUNT-1:0][BUS_WIDTH-1:0] o_out
);

  always_comb begin
    // NOTE: full default before the selective assignment keeps this purely combinational (no latch).
    o_out        = '0;
    o_out[i_sel] = i_in;
  end

endmodule

// File: rtl/reg_file8.sv
// 8 x BUS_WIDTH register file: one write port, two registered read ports with
// write-first bypass, and a sequential clear FSM that zeroes one entry per cycle.
module reg_file8
  import reg_file8_pkg::*;
#(
  parameter int BUS_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [ADDR_W-1:0]    wr_addr,
  input  logic [BUS_WIDTH-1:0] wr_data,
  input  logic [ADDR_W-1:0]    rd_addr_a,
  output logic [BUS_WIDTH-1:0] rd_data_a,
  input  logic [ADDR_W-1:0]    rd_addr_b,
  output logic [BUS_WIDTH-1:0] rd_data_b,
  input  logic                 clr_req,
  output logic                 busy
);

  state_e                 r_state;
  logic [ADDR_W-1:0]      r_ptr;
  logic [BUS_WIDTH-1:0]   r_regs [REG_COUNT];
  logic [BUS_WIDTH-1:0]   r_rd_data_a;
  logic [BUS_WIDTH-1:0]   r_rd_data_b;

  logic                        w_clearing;
  logic                        w_wr_fire;
  logic                        w_wr_strobe;
  logic [ADDR_W-1:0]           w_wr_addr;
  logic [BUS_WIDTH-1:0]        w_wr_data;
  logic [REG_COUNT-1:0][0:0]   w_we;

  assign w_clearing  = (r_state == CLEAR);
  assign wr_ready    = (r_state == IDLE) & ~rst;
  assign busy        = w_clearing;
  assign w_wr_fire   = wr_valid & wr_ready;

  // The clear sequence owns the single write path while it runs.
  assign w_wr_strobe = w_clearing | w_wr_fire;
  assign w_wr_addr   = w_clearing ? r_ptr : wr_addr;
  assign w_wr_data   = w_clearing ? '0 : wr_data;

  dmux8 #(
    .BUS_WIDTH (1)
  ) u_we_dec (
    .i_in  (w_wr_strobe),
    .i_sel (w_wr_addr),
    .o_out (w_we)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_ptr   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (clr_req) begin
            r_state <= CLEAR;
            r_ptr   <= '0;
          end
        end
        CLEAR: begin
          if (r_ptr == ADDR_W'(REG_COUNT - 1)) begin
            r_state <= IDLE;
            r_ptr   <= '0;
          end else begin
            r_ptr <= r_ptr + 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_ptr   <= '0;
        end
      endcase
    end
  end

  // NOTE: storage is reset because zeroed contents after reset are visible, specified behaviour.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REG_COUNT; i++) r_regs[i] <= '0;
    end else begin
      for (int i = 0; i < REG_COUNT; i++) begin
        if (w_we[i][0]) r_regs[i] <= w_wr_data;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_data_a <= '0;
      r_rd_data_b <= '0;
    end else begin
      r_rd_data_a <= (w_wr_strobe && (w_wr_addr == rd_addr_a)) ? w_wr_data : r_regs[rd_addr_a];
      r_rd_data_b <= (w_wr_strobe && (w_wr_addr == rd_addr_b)) ? w_wr_data : r_regs[rd_addr_b];
    end
  end

  assign rd_data_a = r_rd_data_a;
  assign rd_data_b = r_rd_data_b;

endmodule

// File: tb/tb_reg_file8.sv
// Self-checking bench for reg_file8: directed scenarios plus randomized traffic
// compared against an array-based model of the register file and clear sequence.
module tb_reg_file8;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_valid;
  logic        wr_ready;
  logic [2:0]  wr_addr;
  logic [15:0] wr_data;
  logic [2:0]  rd_addr_a;
  logic [15:0] rd_data_a;
  logic [2:0]  rd_addr_b;
  logic [15:0] rd_data_b;
  logic        clr_req;
  logic        busy;

  int n_total = 0;
  int n_pass  = 0;

  // Model: register contents, read results and cycles of clearing still to run.
  logic [15:0] m_regs [8];
  logic [15:0] m_rd_a;
  logic [15:0] m_rd_b;
  int          m_clear_left;

  reg_file8 #(.BUS_WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_addr_a (rd_addr_a),
    .rd_data_a (rd_data_a),
    .rd_addr_b (rd_addr_b),
    .rd_data_b (rd_data_b),
    .clr_req   (clr_req),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_regs[i] = '0;
    m_rd_a = '0;
    m_rd_b = '0;
    m_clear_left = 0;
  endtask

  // Advance model by one edge with the currently driven inputs, then clock the DUT.
  task automatic step();
    logic [15:0] nxt [8];
    nxt = m_regs;
    if (wr_valid && m_clear_left == 0) nxt[wr_addr] = wr_data;
    if (m_clear_left > 0) nxt[8 - m_clear_left] = '0;
    m_rd_a = nxt[rd_addr_a];
    m_rd_b = nxt[rd_addr_b];
    if (m_clear_left > 0) m_clear_left--;
    else if (clr_req) m_clear_left = 8;
    m_regs = nxt;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wr_valid = 0; wr_addr = 0; wr_data = 0; clr_req = 0;
  endtask

  task automatic wait_not_busy(input string name);
    int n = 0;
    while (busy && n < 20) begin
      step();
      n++;
    end
    n_total++;
    if (busy !== 1'b0) $display("FAIL %s: busy still %b after %0d cycles, required 0", name, busy, n);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1; idle_inputs(); rd_addr_a = 0; rd_addr_b = 0;
    model_reset();
    #12;
    n_total++;
    if ({busy, wr_ready} !== 2'b00) $display("FAIL reset_flags: busy/ready=%b, required 00", {busy, wr_ready});
    else n_pass++;
    n_total++;
    if ({rd_data_a, rd_data_b} !== 32'h0) $display("FAIL reset_rd: got %h, required 0", {rd_data_a, rd_data_b});
    else n_pass++;
    rst = 0;
    #1;
    n_total++;
    if (wr_ready !== 1'b1) $display("FAIL reset_release_ready: got %b, required 1", wr_ready);
    else n_pass++;
  endtask

  task automatic test_basic();
    wr_valid = 1; wr_addr = 5; wr_data = 16'h1234; rd_addr_a = 0; rd_addr_b = 2;
    step();
    wr_valid = 0; rd_addr_a = 5;
    step();
    n_total++;
    if (rd_data_a !== 16'h1234) $display("FAIL basic_rd_a: got %h, required 1234", rd_data_a);
    else n_pass++;
    n_total++;
    if (rd_data_b !== 16'h0000) $display("FAIL basic_rd_b_unwritten: got %h, required 0000", rd_data_b);
    else n_pass++;
  endtask

  task automatic test_bypass();
    wr_valid = 1; wr_addr = 3; wr_data = 16'hBEEF; rd_addr_a = 3; rd_addr_b = 3;
    step();
    wr_valid = 0;
    n_total++;
    if (rd_data_a !== 16'hBEEF) $display("FAIL bypass_a: got %h, required beef", rd_data_a);
    else n_pass++;
    n_total++;
    if (rd_data_b !== 16'hBEEF) $display("FAIL bypass_b: got %h, required beef", rd_data_b);
    else n_pass++;
  endtask

  task automatic test_clear();
    int busy_cycles = 0;
    int accept_at = -1;
    for (int i = 0; i < 8; i++) begin
      wr_valid = 1; wr_addr = 3'(i); wr_data = 16'(i + 1);
      step();
    end
    wr_valid = 0; clr_req = 1;
    step();
    clr_req = 0;
    wr_valid = 1; wr_addr = 0; wr_data = 16'hAAAA;
    for (int i = 0; i < 12; i++) begin
      rd_addr_a = 3'(i); rd_addr_b = 3'(i + 1);
      if (busy) busy_cycles++;
      n_total++;
      if (wr_ready !== !busy) $display("FAIL clear_ready_vs_busy: ready=%b busy=%b cycle %0d", wr_ready, busy, i);
      else n_pass++;
      if (wr_valid && wr_ready) accept_at = i;
      step();
      if (accept_at == i) wr_valid = 0;
      n_total++;
      if ({rd_data_a, rd_data_b} !== {m_rd_a, m_rd_b})
        $display("FAIL clear_reads: got %h/%h, required %h/%h cycle %0d", rd_data_a, rd_data_b, m_rd_a, m_rd_b, i);
      else n_pass++;
    end
    n_total++;
    if (busy_cycles !== 8) $display("FAIL clear_busy_len: got %0d cycles, required 8", busy_cycles);
    else n_pass++;
    n_total++;
    if (accept_at !== 8) $display("FAIL clear_held_write: accepted at %0d, required 8", accept_at);
    else n_pass++;
    for (int i = 0; i < 8; i++) begin
      rd_addr_a = 3'(i); rd_addr_b = 3'(7 - i);
      step();
      n_total++;
      if (rd_data_a !== ((i == 0) ? 16'hAAAA : 16'h0))
        $display("FAIL clear_final_reg%0d: got %h", i, rd_data_a);
      else n_pass++;
    end
  endtask

  task automatic test_collision();
    wr_valid = 1; wr_addr = 7; wr_data = 16'h5555; clr_req = 1; rd_addr_a = 0;
    step();
    wr_valid = 0; clr_req = 0; rd_addr_a = 7; rd_addr_b = 7;
    step();
    n_total++;
    if (rd_data_a !== 16'h5555) $display("FAIL collision_commit: got %h, required 5555", rd_data_a);
    else n_pass++;
    wait_not_busy("collision_drain");
    step();
    n_total++;
    if (rd_data_b !== 16'h0000) $display("FAIL collision_cleared: got %h, required 0000", rd_data_b);
    else n_pass++;
  endtask

  task automatic test_reset_mid_clear();
    clr_req = 1;
    step();
    clr_req = 0;
    step(); step(); step();
    #2 rst = 1;
    #1;
    model_reset();
    n_total++;
    if ({rd_data_a, rd_data_b, busy, wr_ready} !== 34'h0)
      $display("FAIL rst_mid_clear_async: rd=%h/%h busy=%b ready=%b, required all 0", rd_data_a, rd_data_b, busy, wr_ready);
    else n_pass++;
    @(posedge clk);
    #3 rst = 0;
    #1;
    n_total++;
    if ({busy, wr_ready} !== 2'b01) $display("FAIL rst_mid_clear_release: busy/ready=%b, required 01", {busy, wr_ready});
    else n_pass++;
    wr_valid = 1; wr_addr = 6; wr_data = 16'h0F0F;
    step();
    wr_valid = 0;
    for (int i = 0; i < 8; i++) begin
      rd_addr_a = 3'(i); rd_addr_b = 6;
      step();
      n_total++;
      if (rd_data_a !== m_rd_a) $display("FAIL rst_mid_clear_reg%0d: got %h, required %h", i, rd_data_a, m_rd_a);
      else n_pass++;
    end
    n_total++;
    if (rd_data_b !== 16'h0F0F) $display("FAIL rst_mid_clear_write: got %h, required 0f0f", rd_data_b);
    else n_pass++;
  endtask

  task automatic test_rerequest();
    logic obs [18];
    clr_req = 1;
    step();
    for (int i = 0; i < 18; i++) begin
      obs[i] = busy;
      step();
    end
    clr_req = 0;
    for (int i = 0; i < 18; i++) begin
      n_total++;
      if (obs[i] !== ((i % 9) != 8)) $display("FAIL rerequest_busy_c%0d: got %b, required %b", i, obs[i], (i % 9) != 8);
      else n_pass++;
    end
    wait_not_busy("rerequest_drain");
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      wr_valid  = 1'($urandom_range(0, 1));
      wr_addr   = 3'($urandom);
      wr_data   = 16'($urandom);
      rd_addr_a = 3'($urandom);
      rd_addr_b = 3'($urandom);
      clr_req   = ($urandom_range(0, 24) == 0);
      step();
      n_total++;
      if ({rd_data_a, rd_data_b} !== {m_rd_a, m_rd_b})
        $display("FAIL random_rd c%0d: got %h/%h, required %h/%h", i, rd_data_a, rd_data_b, m_rd_a, m_rd_b);
      else n_pass++;
      n_total++;
      if ({busy, wr_ready} !== {m_clear_left > 0, m_clear_left == 0})
        $display("FAIL random_flags c%0d: busy/ready=%b%b, required %b%b", i, busy, wr_ready, m_clear_left > 0, m_clear_left == 0);
      else n_pass++;
    end
    idle_inputs();
    wait_not_busy("random_drain");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bypass();
    test_clear();
    test_collision();
    test_reset_mid_clear();
    test_rerequest();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/reg_file8.md
REG_FILE8 -- requirements
Module: reg_file8

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-002 Parameter: BUS_WIDTH, default 16, the data width of each register and each data port.
REQ-003 Port: clk  input  1  rising-edge clock for all state.
REQ-004 Port: rst  input  1  asynchronous active-high reset.
REQ-005 Port: wr_valid  input  1  write request present.
REQ-006 Port: wr_ready  output  1  block can accept a write this cycle.
REQ-007 Port: wr_addr  input  3  target register index.
REQ-008 Port: wr_data  input  BUS_WIDTH  write data.
REQ-009 Port: rd_addr_a  input  3  read port A index.
REQ-010 Port: rd_data_a  output  BUS_WIDTH  registered read data, port A.
REQ-011 Port: rd_addr_b  input  3  read port B index.
REQ-012 Port: rd_data_b  output  BUS_WIDTH  registered read data, port B.
REQ-013 Port: clr_req  input  1  request a sequential clear of all registers.
REQ-014 Port: busy  output  1  clear sequence in progress.

Function
REQ-015 The block SHALL store 8 registers of BUS_WIDTH bits, indexed 0..7.
REQ-016 A write SHALL be accepted at a rising edge where wr_valid=1 and wr_ready=1; regs[wr_addr] takes wr_data at that edge; no other register changes.
REQ-017 wr_valid SHALL be ignored when wr_ready=0; the requester holds wr_valid, wr_addr and wr_data until accepted.
REQ-018 wr_ready SHALL equal (state==IDLE) & ~rst, derived combinationally from registered state.
REQ-019 Each read port SHALL have 1-cycle latency: at every rising edge, rd_data_x captures regs[rd_addr_x].
REQ-020 Write-first bypass: if a write (handshake or clear) targets rd_addr_x at the same edge, rd_data_x SHALL capture the written value, not the old contents.
REQ-021 Both read ports SHALL operate independently and may address the same register.
REQ-022 FSM states: IDLE, CLEAR. In IDLE with clr_req=1 at a rising edge: go to CLEAR, ptr=0.
REQ-023 In CLEAR, each rising edge SHALL write 0 to regs[ptr] and increment ptr. At ptr=7 the edge writes regs[7]=0 and returns to IDLE with ptr=0. The sequence occupies exactly 8 cycles.
REQ-024 busy SHALL be 1 exactly while state==CLEAR.
REQ-025 clr_req while in CLEAR SHALL be ignored; it does not restart or extend the sequence.
REQ-026 clr_req and an accepted write at the same IDLE edge: the write SHALL commit, then the clear overwrites it.
REQ-027 ptr SHALL be 3 bits; ptr increments wrap only through the CLEAR→IDLE transition, never mid-sequence.
REQ-028 Reads during CLEAR SHALL return current contents, including zeros written earlier in the sequence and the bypassed zero at the same edge.

Reset
REQ-029 rst=1 SHALL immediately, without a clock, force:
- all 8 registers, rd_data_a and rd_data_b to 0;
- state to IDLE and ptr to 0;
- busy to 0 and wr_ready to 0.
REQ-030 rst asserted mid-clear SHALL abort the sequence; after deassertion the block is in IDLE with wr_ready=1 on the next cycle.
REQ-031 The first write SHALL be accepted at the first rising edge with rst=0 and wr_valid=1.

Structure
REQ-032 The following SHALL reside in the shared constants package/header:
- register count (8);
- address width (3);
- FSM state encoding (IDLE=0, CLEAR=1).
REQ-033 The write-enable one-hot decode SHALL reuse the existing dmux8 block (BUS_WIDTH=1), with input = write strobe and sel = effective write address (ptr in CLEAR, wr_addr otherwise).
REQ-034 No other sub-module is required; storage, bypass and FSM are inline.

Verification
REQ-035 Basic write/read: write 0x1234 to reg 5 (accepted), then rd_addr_a=5 → rd_data_a=0x1234 one cycle later; rd_data_b for unwritten reg 2 = 0x0000.
REQ-036 Bypass: at a single edge, write 0xBEEF to reg 3 with rd_addr_a=rd_addr_b=3 → both read ports show 0xBEEF after that edge.
REQ-037 Clear: fill regs with 0x0001..0x0008, pulse clr_req.
- busy=1 and wr_ready=0 for 8 cycles.
- A held write of 0xAAAA to reg 0 is accepted only on the first IDLE cycle.
- Final state: regs 1..7 = 0 and reg 0 = 0xAAAA.
REQ-038 Collision: clr_req and a write of 0x5555 to reg 7 in the same IDLE cycle → write commits, then reg 7 = 0 after the sequence.
REQ-039 Reset mid-clear: assert rst asynchronously at clear cycle 4 → all outputs 0 at once; after release, busy=0 and wr_ready=1; a write of 0x0F0F to reg 6 then reads back 0x0F0F.
REQ-040 Re-request ignored: clr_req held high throughout CLEAR → exactly 8 busy cycles, then a second 8-cycle sequence starts only because clr_req is still high in IDLE.
